sync_fifo_param: RTL and testbench
==================================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
- REQ-001: The block SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
- REQ-002: The block SHALL have parameter DEPTH, default 16, number of storage entries (power of two, >=4).
- REQ-003: The block SHALL have parameter AFULL_TH, default 12, count at or above which almost_full asserts (1..DEPTH-1).
- REQ-004: The block SHALL have parameter AEMPTY_TH, default 4, count at or below which almost_empty asserts (1..DEPTH-1).
- REQ-005: The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
- REQ-006: The block SHALL have port rst, input, 1, synchronous active-high reset.
- REQ-007: The block SHALL have port wr, input, 1, write request.
- REQ-008: The block SHALL have port din, input, WIDTH, write data.
- REQ-009: The block SHALL have port rd, input, 1, read request.
- REQ-010: The block SHALL have port dout, output reg, WIDTH, read data.
- REQ-011: The block SHALL have port full, output, 1, count == DEPTH.
- REQ-012: The block SHALL have port empty, output, 1, count == 0.
- REQ-013: The block SHALL have port almost_full, output, 1, count >= AFULL_TH.
- REQ-014: The block SHALL have port almost_empty, output, 1, count <= AEMPTY_TH.
- REQ-015: The block SHALL have port count, output, $clog2(DEPTH+1), current occupancy.
- REQ-016: The block SHALL have port overflow, output reg, 1, one-cycle pulse for a rejected write.
- REQ-017: The block SHALL have port underflow, output reg, 1, one-cycle pulse for a rejected read.

Function
- REQ-018: Read acceptance SHALL be rd_ok = rd && !empty.
- REQ-019: Write acceptance SHALL be wr_ok = wr && (!full || rd); a write into a full FIFO with a simultaneous read is accepted.
- REQ-020: On wr_ok, din SHALL be stored at mem[wptr], and wptr SHALL increment modulo DEPTH (natural wrap, log2(DEPTH)-bit pointer).
- REQ-021: On rd_ok, dout SHALL load mem[rptr] at the same edge (1-cycle read latency), and rptr SHALL increment modulo DEPTH.
- REQ-022: dout SHALL hold its value when there is no rd_ok.
- REQ-023: count SHALL change as follows: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither occur.
- REQ-024: Simultaneous rd_ok and wr_ok when full SHALL return the oldest word; the new word SHALL occupy the freed slot, and full SHALL remain 1.
- REQ-025: Simultaneous rd and wr when empty SHALL give write accepted, read rejected, underflow pulsed, and count becomes 1.
- REQ-026: overflow SHALL be 1 in the cycle after an edge where wr && !wr_ok, and 0 otherwise.
- REQ-027: underflow SHALL be 1 in the cycle after an edge where rd && !rd_ok, and 0 otherwise.
- REQ-028: full, empty, almost_full and almost_empty SHALL be combinational decodes of registered count (no extra latency).
- REQ-029: Rejected operations SHALL NOT alter memory, pointers, count or dout.
- REQ-030: Data SHALL be read out in strict write order across any number of pointer wraps.

Reset
- REQ-031: When rst=1 at a rising edge, wptr, rptr and count SHALL clear to 0, dout to 0, and overflow and underflow to 0; rst overrides wr and rd.
- REQ-032: After reset, outputs SHALL be empty=1, almost_empty=1, full=0, almost_full=0 and count=0.
- REQ-033: Memory contents SHALL NOT be cleared by reset; stale data SHALL never be readable because empty=1.
- REQ-034: Reset asserted mid-operation, including while full, SHALL discard all contents in one cycle.

Verification (defaults WIDTH=8, DEPTH=16)
- REQ-035: Write 0x00..0x0F, then a 17th write 0xAA -> full=1 after the 16th write, count=16, overflow=1 for one cycle, and the 0xAA write is dropped.
- REQ-036: From full, read 16 times -> dout=0x00..0x0F in order, each one cycle after rd; empty=1 at the end; a 17th read gives underflow=1 and dout holds 0x0F.
- REQ-037: From full, assert wr=1 din=0x55 and rd=1 together -> dout=0x00, count stays 16, and 0x55 is read out last, after 0x0F.
- REQ-038: From empty, assert wr=1 din=0x33 and rd=1 together -> underflow=1, count=1, and the next read returns 0x33.
- REQ-039: Fill to 12 -> almost_full rises on the count 11->12 edge; drain to 4 -> almost_empty rises on the count 5->4 edge.
- REQ-040: Perform 40 mixed writes/reads crossing the pointer wrap, assert rst at count=7 -> the next cycle shows count=0, empty=1, dout=0x00, and further reads give underflow.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered read data, occupancy count, threshold flags
// and one-cycle overflow/underflow pulses for rejected requests.
module sync_fifo_param #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_TH  = 12,
  parameter int unsigned AEMPTY_TH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [CntW-1:0] DepthCnt  = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfullTh   = CntW'(AFULL_TH);
  localparam logic [CntW-1:0] AemptyTh  = CntW'(AEMPTY_TH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic wr_ok;
  logic rd_ok;

  assign full         = (count_q == DepthCnt);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AfullTh);
  assign almost_empty = (count_q <= AemptyTh);

  assign count     = count_q;
  assign dout      = dout_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // A write into a full FIFO is allowed when a read frees a slot in the same cycle.
  assign rd_ok = rd && !empty;
  assign wr_ok = wr && (!full || rd);

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    dout_d      = dout_q;
    overflow_d  = wr && !wr_ok;
    underflow_d = rd && !rd_ok;

    if (wr_ok) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (rd_ok) begin
      rptr_d = rptr_q + PtrW'(1);
      dout_d = mem_q[rptr_q];
    end

    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; empty guards stale contents.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem_q[wptr_q] <= din;
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param at default parameters (WIDTH=8, DEPTH=16).
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic [7:0] din;
  logic       rd;
  logic [7:0] dout;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int errors = 0;
  int checks = 0;

  sync_fifo_param #(
    .WIDTH    (8),
    .DEPTH    (16),
    .AFULL_TH (12),
    .AEMPTY_TH(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr          (wr),
    .din         (din),
    .rd          (rd),
    .dout        (dout),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs; return 1 time unit after the rising edge.
  task automatic cyc(input logic t_rst, input logic t_wr, input logic [7:0] t_din,
                     input logic t_rd);
    rst = t_rst;
    wr  = t_wr;
    din = t_din;
    rd  = t_rd;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_d;
  logic       w_k;
  logic       r_k;

  initial begin
    rst = 1'b1;
    wr  = 1'b0;
    din = 8'h00;
    rd  = 1'b0;
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);

    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_udf", 32'(underflow), 32'd0);

    // Fill 0x00..0x0F, watching threshold edges.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 8'(i), 1'b0);
      if (i == 3)  chk("fill1_aempty_at4", 32'(almost_empty), 32'd1);
      if (i == 4)  chk("fill1_aempty_at5", 32'(almost_empty), 32'd0);
      if (i == 10) chk("fill1_afull_at11", 32'(almost_full), 32'd0);
      if (i == 11) chk("fill1_afull_at12", 32'(almost_full), 32'd1);
      if (i == 14) chk("fill1_full_at15", 32'(full), 32'd0);
    end
    chk("fill1_count", 32'(count), 32'd16);
    chk("fill1_full", 32'(full), 32'd1);
    chk("fill1_ovf", 32'(overflow), 32'd0);

    cyc(1'b0, 1'b1, 8'hAA, 1'b0);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Drain in order; 0xAA must not appear.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      chk("drain1_dout", 32'(dout), 32'(i));
      chk("drain1_count", 32'(count), 32'(15 - i));
    end
    chk("drain1_empty", 32'(empty), 32'd1);
    chk("drain1_udf0", 32'(underflow), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("udf_pulse", 32'(underflow), 32'd1);
    chk("udf_dout_hold", 32'(dout), 32'h0F);
    chk("udf_count", 32'(count), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("udf_clear", 32'(underflow), 32'd0);

    // Refill, then simultaneous read/write while full.
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
    chk("fill2_full", 32'(full), 32'd1);
    cyc(1'b0, 1'b1, 8'h55, 1'b1);
    chk("rw_full_dout", 32'(dout), 32'h10);
    chk("rw_full_count", 32'(count), 32'd16);
    chk("rw_full_full", 32'(full), 32'd1);
    chk("rw_full_ovf", 32'(overflow), 32'd0);

    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      chk("drain2_dout", 32'(dout), (i < 15) ? 32'(8'h11 + i) : 32'h55);
      if (i == 10) chk("drain2_aempty_at5", 32'(almost_empty), 32'd0);
      if (i == 11) chk("drain2_aempty_at4", 32'(almost_empty), 32'd1);
      if (i == 3)  chk("drain2_afull_at12", 32'(almost_full), 32'd1);
      if (i == 4)  chk("drain2_afull_at11", 32'(almost_full), 32'd0);
    end
    chk("drain2_empty", 32'(empty), 32'd1);

    // Simultaneous read/write while empty: write wins, read rejected.
    cyc(1'b0, 1'b1, 8'h33, 1'b1);
    chk("rw_empty_udf", 32'(underflow), 32'd1);
    chk("rw_empty_count", 32'(count), 32'd1);
    chk("rw_empty_dout_hold", 32'(dout), 32'h55);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("rw_empty_read", 32'(dout), 32'h33);
    chk("rw_empty_udf_clear", 32'(underflow), 32'd0);
    chk("rw_empty_count0", 32'(count), 32'd0);

    // 40 mixed ops across pointer wraps: 10 writes, 27 read+write, 3 reads.
    for (int k = 0; k < 40; k++) begin
      w_k = (k < 37);
      r_k = (k >= 10);
      if (r_k) exp_d = q.pop_front();
      if (w_k) q.push_back(8'(8'h40 + k));
      cyc(1'b0, w_k, 8'(8'h40 + k), r_k);
      if (r_k) chk("mixed_dout", 32'(dout), 32'(exp_d));
    end
    chk("mixed_count7", 32'(count), 32'd7);

    cyc(1'b1, 1'b1, 8'hEE, 1'b1);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_dout", 32'(dout), 32'd0);
    chk("midrst_udf", 32'(underflow), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("postrst_udf", 32'(underflow), 32'd1);
    chk("postrst_dout", 32'(dout), 32'd0);
    chk("postrst_count", 32'(count), 32'd0);

    // Reset while full discards everything in one cycle.
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
    chk("fill3_full", 32'(full), 32'd1);
    cyc(1'b1, 1'b1, 8'h99, 1'b1);
    chk("fullrst_count", 32'(count), 32'd0);
    chk("fullrst_empty", 32'(empty), 32'd1);
    chk("fullrst_full", 32'(full), 32'd0);
    chk("fullrst_afull", 32'(almost_full), 32'd0);
    chk("fullrst_ovf", 32'(overflow), 32'd0);
    cyc(1'b0, 1'b1, 8'h77, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("fullrst_first_read", 32'(dout), 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
